// File: rtl/alu_operand_pkg.sv
// Shared encodings and constants for the ALU operand stage.
package alu_operand_pkg;

  typedef enum logic [1:0] {
    SRC_A_PC   = 2'd0,
    SRC_A_REG  = 2'd1,
    SRC_A_MDR  = 2'd2,
    SRC_A_ZERO = 2'd3
  } sel_a_e;

  typedef enum logic [2:0] {
    SRC_B_REG      = 3'd0,
    SRC_B_FOUR     = 3'd1,
    SRC_B_SEXT     = 3'd2,
    SRC_B_SEXT_SH2 = 3'd3,
    SRC_B_A        = 3'd4,
    SRC_B_ZEXT     = 3'd5,
    SRC_B_LUI      = 3'd6,
    SRC_B_SHAMT    = 3'd7
  } sel_b_e;

  localparam logic [31:0] OPERAND_FOUR = 32'd4;

  // Base-width layout; WIDTH-parametrised modules declare the same field order locally.
  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
  } operand_pair_t;

endpackage

// File: rtl/operand_fifo.sv
// In-order circular buffer of operand pairs with synchronous flush.
module operand_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned LW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [2*WIDTH-1:0] wdata,
  output logic [2*WIDTH-1:0] rdata,
  output logic [LW-1:0]      level,
  output logic               full,
  output logic               empty
);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand source selection, immediate extension and optional swap, buffered
// ahead of the ALU through a small valid/ready FIFO.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       sel_a,
  input  logic [2:0]       sel_b,
  input  logic             swap,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] mdr,
  input  logic [15:0]      imm16,
  input  logic [4:0]       shamt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [LW-1:0]    level
);

  typedef struct packed {
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
  } pair_t;

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] imm_zext;
  pair_t            wr_pair;
  pair_t            rd_pair;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign imm_sext = {{(WIDTH-16){imm16[15]}}, imm16};
  assign imm_zext = {{(WIDTH-16){1'b0}}, imm16};

  always_comb begin
    src_a = '0;
    case (sel_a_e'(sel_a))
      SRC_A_PC:   src_a = pc;
      SRC_A_REG:  src_a = a;
      SRC_A_MDR:  src_a = mdr;
      SRC_A_ZERO: src_a = '0;
      default:    src_a = '0;
    endcase
  end

  always_comb begin
    src_b = '0;
    case (sel_b_e'(sel_b))
      SRC_B_REG:      src_b = b;
      SRC_B_FOUR:     src_b = WIDTH'(OPERAND_FOUR);
      SRC_B_SEXT:     src_b = imm_sext;
      SRC_B_SEXT_SH2: src_b = imm_sext << 2;
      SRC_B_A:        src_b = a;
      SRC_B_ZEXT:     src_b = imm_zext;
      SRC_B_LUI:      src_b = imm_zext << 16;
      SRC_B_SHAMT:    src_b = {{(WIDTH-5){1'b0}}, shamt};
      default:        src_b = '0;
    endcase
  end

  always_comb begin
    wr_pair      = '0;
    wr_pair.op_a = swap ? src_b : src_a;
    wr_pair.op_b = swap ? src_a : src_b;
  end

  // reset_n gating keeps in_ready low while reset is held (level is already 0 then).
  assign in_ready  = reset_n && !full && !flush;
  assign push      = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign op_a      = out_valid ? rd_pair.op_a : '0;
  assign op_b      = out_valid ? rd_pair.op_b : '0;

  operand_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   (wr_pair),
    .rdata   (rd_pair),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

endmodule
